clken_gen: RTL and testbench
============================

Name: clken_gen

Overview:
- Parametrised successor to the fixed 1/2/4 MHz clock-enable divider in the vic20 top level.
- Derives the CPU, VIA and fast-VIA (ENA_4) clock enables from the single 25 MHz system clock.
- Adds four capabilities: generic period and window, clamped turbo levels applied only on a period boundary, a stall input for bus arbitration, and a saturating missed-cycle counter for diagnostics.
- Sits between the PLL clock and the CPU/VIA instances.

Parameters:
- PERIOD, 25: system cycles per base period; the counter runs 0..PERIOD-1.
- WINDOW, 16: counter values 0..WINDOW-1 may produce enables; WINDOW <= PERIOD.
- BASE_DIV, 16: CPU enable divisor at turbo 0; power of 2; WINDOW % BASE_DIV == 0.
- MAX_TURBO, 2: highest turbo level; CPU divisor = BASE_DIV >> level.
- TW, 2: turbo input width; MAX_TURBO <= 2^TW - 1.

Ports:
- clk, input, 1: system clock (25 MHz).
- reset_n, input, 1: asynchronous active-low reset.
- turbo, input, TW: requested turbo level.
- stall, input, 1: suppress CPU and VIA enables while high.
- clr_missed, input, 1: synchronous clear of missed.
- cpu_clken, output, 1: CPU RDY enable.
- cpu_clken_d1, output, 1: cpu_clken delayed by one clk.
- via_clken, output, 1: VIA I_P2_H enable.
- fast_clken, output, 1: VIA ENA_4 enable.
- turbo_applied, output, TW: turbo level currently in effect.
- missed, output, 8: count of suppressed CPU enables.

Behaviour:
- Reset while reset_n is low, asynchronous:
  - cnt = 0 and turbo_applied = 0.
  - All enables = 0.
  - missed = 0.
- Counter:
  - cnt has width $clog2(PERIOD).
  - cnt increments every clk and wraps from PERIOD-1 to 0.
- Turbo update:
  - On the edge where cnt == PERIOD-1, turbo_applied <= min(turbo, MAX_TURBO).
  - No other edge changes turbo_applied, so a mid-period turbo change never produces a short or extra pulse.
- Divisors:
  - D = BASE_DIV >> turbo_applied.
  - F = max(1, D/4).
- Enables, all registered; each is evaluated from the pre-edge cnt, so it is high on the cycle after cnt held the matching value:
  - fast_clken <= (cnt < WINDOW) && (cnt % F == 0).
  - p = (cnt < WINDOW) && (cnt % D == 0).
  - cpu_clken <= p && !stall.
  - via_clken <= p && !stall.
  - cpu_clken_d1 <= cpu_clken.
- Stall rules:
  - stall is sampled on the same edge as cnt.
  - A suppressed pulse is dropped, not deferred.
  - fast_clken is never affected by stall, so VIA timers keep counting.
- Missed counter:
  - On an edge where p && stall, missed increments, saturating at 255.
  - clr_missed has priority over an increment on the same edge; the result is 0.
- Pulse width: every enable is exactly one clk high per firing. Enables never fire for cnt >= WINDOW.
- Release from reset:
  - The first edge after reset_n rises sees cnt == 0, so cpu_clken, via_clken and fast_clken = 1 after that edge, and cnt = 1.
  - cpu_clken_d1 follows one edge later.
- Reset mid-period: everything returns to reset values immediately, with no partial pulse. Counting restarts per the release rule.
- Pulses per period at defaults:
  - turbo 0: 1 CPU, 4 fast.
  - turbo 1: 2 CPU, 8 fast.
  - turbo 2: 4 CPU, 16 fast.

Test Plan:
- Defaults, turbo=0, stall=0, run 100 clk:
  - cpu_clken high exactly at cycles 1, 26, 51, 76 after release.
  - fast_clken high at offsets 1, 5, 9, 13 within each period.
  - cpu_clken_d1 lags cpu_clken by 1.
- turbo=2 held from reset:
  - First period still uses level 0 (1 CPU pulse).
  - From the second period: 4 CPU pulses at offsets 1, 5, 9, 13, and 16 consecutive fast_clken cycles.
  - turbo_applied=2 after the first wrap.
- turbo 0->1 asserted at cnt=5:
  - No extra pulse in the current period.
  - Next period has CPU pulses at offsets 1 and 9.
- turbo=3 with MAX_TURBO=2: turbo_applied=2 and behaviour identical to turbo=2.
- stall=1 for 3 full periods at turbo 0:
  - No cpu_clken or via_clken pulses.
  - fast_clken unchanged.
  - missed=3.
  - Pulse clr_missed together with a suppressed pulse: missed=0.
- reset_n low at cnt=10 with turbo_applied=1:
  - Outputs go to 0 immediately and turbo_applied=0.
  - After release, cpu_clken=1 one edge later.

Source files
------------

// File: rtl/clken_gen_if.sv
// clken_gen_if: turbo/stall/diagnostic controls in, CPU/VIA clock enables out
//   turbo         requested turbo level (clamped by the generator)
//   stall         suppress CPU/VIA enables for bus arbitration
//   clr_missed    synchronous clear of the missed counter
//   cpu_clken     CPU RDY enable;  cpu_clken_d1  same, one clk later
//   via_clken     VIA I_P2_H enable;  fast_clken  VIA ENA_4 enable
//   turbo_applied turbo level currently in effect
//   missed        saturating count of stalled-away CPU enables
interface clken_gen_if #(
    parameter int TW = 2
);
    logic [TW-1:0] turbo;
    logic          stall;
    logic          clr_missed;
    logic          cpu_clken;
    logic          cpu_clken_d1;
    logic          via_clken;
    logic          fast_clken;
    logic [TW-1:0] turbo_applied;
    logic [7:0]    missed;

    modport master (
        output turbo, stall, clr_missed,
        input  cpu_clken, cpu_clken_d1, via_clken, fast_clken, turbo_applied, missed
    );

    modport slave (
        input  turbo, stall, clr_missed,
        output cpu_clken, cpu_clken_d1, via_clken, fast_clken, turbo_applied, missed
    );
endinterface

// File: rtl/clken_gen.sv
// clken_gen: CPU/VIA/fast-VIA clock enables from the system clock with turbo, stall and missed-cycle count
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      clken_gen_if.slave (controls in, enables and diagnostics out)
module clken_gen #(
    parameter int PERIOD    = 25,
    parameter int WINDOW    = 16,
    parameter int BASE_DIV  = 16,
    parameter int MAX_TURBO = 2,
    parameter int TW        = 2
) (
    input logic        clk,
    input logic        reset_n,
    clken_gen_if.slave bus
);
    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] turbo_q, turbo_d;
    logic [7:0]    missed_q, missed_d;
    logic          cpu_q, d1_q, via_q, fast_q;
    logic [31:0]   cnt_w, d_div, f_div;
    logic          in_win, p, fast_hit, wrap;

    // Divisors are powers of two, so the modulo reduces to a mask.
    always_comb begin
        cnt_w    = 32'(cnt_q);
        wrap     = cnt_w == 32'(PERIOD - 1);
        d_div    = 32'(BASE_DIV) >> turbo_q;
        f_div    = (d_div >= 32'd4) ? d_div >> 2 : 32'd1;
        in_win   = cnt_w < 32'(WINDOW);
        p        = in_win && ((cnt_w & (d_div - 32'd1)) == 32'd0);
        fast_hit = in_win && ((cnt_w & (f_div - 32'd1)) == 32'd0);
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        // Turbo only changes at the period boundary so no pulse is ever shortened or doubled.
        turbo_d  = !wrap ? turbo_q :
                   (32'(bus.turbo) > 32'(MAX_TURBO)) ? TW'(MAX_TURBO) : bus.turbo;
        missed_d = bus.clr_missed ? 8'd0 :
                   (p && bus.stall && missed_q != 8'hFF) ? missed_q + 8'd1 : missed_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            turbo_q  <= '0;
            missed_q <= '0;
            cpu_q    <= 1'b0;
            d1_q     <= 1'b0;
            via_q    <= 1'b0;
            fast_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            turbo_q  <= turbo_d;
            missed_q <= missed_d;
            cpu_q    <= p && !bus.stall;
            d1_q     <= cpu_q;
            via_q    <= p && !bus.stall;
            fast_q   <= fast_hit;
        end
    end

    assign bus.cpu_clken     = cpu_q;
    assign bus.cpu_clken_d1  = d1_q;
    assign bus.via_clken     = via_q;
    assign bus.fast_clken    = fast_q;
    assign bus.turbo_applied = turbo_q;
    assign bus.missed        = missed_q;
endmodule

// File: tb/tb_clken_gen.sv
// tb_clken_gen: scoreboard bench for clken_gen; expected pulse cycles queued, monitor pops on each pulse
module tb_clken_gen;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc;
    int   n_chk = 0;
    int   n_fail = 0;
    int   q [4][$];
    logic prev_cpu;
    string nm [4] = '{"cpu_clken", "via_clken", "fast_clken", "cpu_clken_d1"};

    clken_gen_if #(.TW(2)) bus ();

    clken_gen dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #20 clk = ~clk;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Index 0 cpu, 1 via, 2 fast, 3 cpu_d1
    always @(negedge clk) begin
        logic [3:0] s;
        int e;
        s = {bus.cpu_clken_d1, bus.fast_clken, bus.via_clken, bus.cpu_clken};
        if (reset_n) begin
            for (int k = 0; k < 4; k++)
                if (s[k]) begin
                    if (q[k].size() == 0) chk({nm[k], "_extra"}, cyc, -1);
                    else begin
                        e = q[k].pop_front();
                        chk(nm[k], cyc, e);
                    end
                end
        end
    end

    task automatic exp_cpu(input int c);
        q[0].push_back(c);
        q[1].push_back(c);
        q[3].push_back(c + 1);
    endtask

    task automatic exp_fast(input int c);
        q[2].push_back(c);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_empty(input string name);
        for (int k = 0; k < 4; k++) begin
            chk({name, "_", nm[k], "_missing"}, q[k].size(), 0);
            q[k].delete();
        end
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        #1;
        chk("rst_cpu", bus.cpu_clken, 0);
        chk("rst_d1", bus.cpu_clken_d1, 0);
        chk("rst_via", bus.via_clken, 0);
        chk("rst_fast", bus.fast_clken, 0);
        chk("rst_turbo", bus.turbo_applied, 0);
        chk("rst_missed", bus.missed, 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Period 0 at level 0, then full turbo 2 pattern from cycle 26.
    task automatic turbo_from_reset(input logic [1:0] t);
        bus.turbo = t;
        do_reset();
        exp_cpu(1);
        for (int i = 0; i < 4; i++) exp_fast(1 + 4 * i);
        for (int i = 0; i < 4; i++) exp_cpu(26 + 4 * i);
        for (int i = 0; i < 16; i++) exp_fast(26 + i);
        tick(24);
        chk("turbo_before_wrap", bus.turbo_applied, 0);
        tick(1);
        chk("turbo_after_wrap", bus.turbo_applied, 2);
        tick(25);
        check_empty("turbo_hold");
    endtask

    initial begin
        bus.turbo = 2'd0;
        bus.stall = 1'b0;
        bus.clr_missed = 1'b0;

        // Defaults: one CPU and four fast pulses per 25-cycle period
        do_reset();
        for (int n = 0; n < 4; n++) begin
            exp_cpu(1 + 25 * n);
            for (int i = 0; i < 4; i++) exp_fast(1 + 25 * n + 4 * i);
        end
        tick(100);
        check_empty("default");

        turbo_from_reset(2'd2);
        turbo_from_reset(2'd3);

        // Turbo 0 -> 1 mid-period: takes effect only from cycle 26
        bus.turbo = 2'd0;
        do_reset();
        exp_cpu(1);
        for (int i = 0; i < 4; i++) exp_fast(1 + 4 * i);
        exp_cpu(26);
        exp_cpu(34);
        for (int i = 0; i < 8; i++) exp_fast(26 + 2 * i);
        tick(5);
        bus.turbo = 2'd1;
        tick(45);
        chk("turbo_mid", bus.turbo_applied, 1);
        check_empty("turbo_mid");

        // Stall: CPU/VIA dropped, fast untouched, missed counts and saturates
        bus.turbo = 2'd0;
        bus.stall = 1'b1;
        do_reset();
        for (int n = 0; n < 264; n++)
            for (int i = 0; i < 4; i++) exp_fast(1 + 25 * n + 4 * i);
        tick(75);
        chk("missed_3", bus.missed, 3);
        bus.clr_missed = 1'b1;
        tick(1);
        chk("missed_clr", bus.missed, 0);
        bus.clr_missed = 1'b0;
        tick(1);
        chk("missed_after_clr", bus.missed, 0);
        tick(24);
        chk("missed_1", bus.missed, 1);
        tick(6499);
        chk("missed_sat", bus.missed, 255);
        check_empty("stall");
        bus.stall = 1'b0;

        // Reset mid-period at cnt 10 with turbo 1 applied
        bus.turbo = 2'd1;
        do_reset();
        exp_cpu(1);
        for (int i = 0; i < 4; i++) exp_fast(1 + 4 * i);
        exp_cpu(26);
        exp_cpu(34);
        for (int i = 0; i < 5; i++) exp_fast(26 + 2 * i);
        tick(35);
        chk("turbo_pre_reset", bus.turbo_applied, 1);
        check_empty("pre_reset");
        bus.turbo = 2'd0;
        do_reset();
        exp_cpu(1);
        exp_fast(1);
        tick(1);
        chk("release_cpu", bus.cpu_clken, 1);
        tick(1);
        check_empty("release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
